lspc_vram_sched: RTL and testbench
==================================

# lspc_vram_sched

Time-slot scheduler for LSPC video RAM. Shares the lower (32K×16) and upper (2K×16) VRAM between the renderer fetch port and the 68K register port (VRAMADDR / VRAMRW / VRAMMOD) on a fixed 16-clock frame at CLK_24M. Sits between the LSPC register decode and the VRAM chips, and owns every VRAM strobe.

## Interface
Parameters:
- FIFO_DEPTH, 2, CPU write queue entries (power of two, ≥2)

Ports:
- CLK_24M  in  1  master clock; all logic on rising edge
- RESET  in  1  synchronous, active-high
- CPU_ADDR_WE  in  1  1-clock pulse: load VRAMADDR from CPU_DATA, start prefetch
- CPU_RW_WE  in  1  1-clock pulse: queue write of CPU_DATA at VRAMADDR
- CPU_MOD_WE  in  1  1-clock pulse: load VRAMMOD from CPU_DATA
- CPU_DATA  in  16  CPU write data
- CPU_RDATA  out  16  read latch (prefetched word at VRAMADDR)
- CPU_VRAMADDR  out  16  current address register
- CPU_VRAMMOD  out  16  modulo register
- CPU_BUSY  out  1  write queue not empty
- CPU_OVF  out  1  sticky: write dropped on full queue
- REN_REQ  in  1  renderer read request, sampled at window start
- REN_ADDR  in  16  renderer address
- REN_ACK  out  1  request accepted (window start +1)
- REN_VALID  out  1  REN_DATA valid, 1 clock
- REN_DATA  out  16  renderer read data
- B  out  15  lower VRAM address
- nBOE, nBWE  out  1  lower VRAM strobes
- E_OUT / E_IN  out / in  16  lower VRAM data; E_OE out 1 drive enable
- C  out  11  upper VRAM address
- nCWE  out  1  upper VRAM write strobe (upper VRAM always output-enabled)
- F_OUT / F_IN  out / in  16  upper VRAM data; F_OE out 1 drive enable

## Operation
- 4-bit SLOT counter, +1 per clock, wraps 15→0. Four windows of 4 clocks begin at SLOT 0, 4, 8, 12.
- Windows 0/4/8: renderer. Window 12: CPU.
- Address decode: bit 15 = 0 → lower VRAM, B = addr[14:0]; bit 15 = 1 → upper VRAM, C = addr[10:0] (bits 14:11 ignored, mirror).
- Window phase k = 0..3:
  - Read: address driven k0–k3; nBOE low k0–k3 (lower only); data captured at the edge ending k2; REN_VALID or the CPU_RDATA update occurs during k3.
  - Write: address and data (E_OE/F_OE) driven k0–k3; nBWE/nCWE low k1–k2 only.
- CPU window priority: queue head write > pending prefetch > idle (all strobes high).
- Completed write: VRAMADDR += VRAMMOD (mod 2^16, value before the edge), then a prefetch is set pending.
- CPU_ADDR_WE: loads VRAMADDR and sets prefetch pending. A prefetch already in flight completes but its result is discarded.
- Queue full (FIFO_DEPTH entries) + CPU_RW_WE: write dropped, CPU_OVF set. Only RESET clears CPU_OVF.
- Each queued entry stores the VRAMADDR value present when it is enqueued.
- Simultaneous CPU_ADDR_WE + CPU_RW_WE: address loads first; the queued write uses the new address.
- CPU_ADDR_WE in the same clock as an auto-increment: the CPU value wins.
- No REN_REQ at a renderer window start: the window idles, unless the slot-steal feature is compiled in.

## Timing
- REN_REQ sampled at SLOT 0/4/8. REN_ACK at +1 clock. REN_VALID/REN_DATA at +3. REN_ADDR must be stable for the 4 clocks of the window.
- CPU write latency: worst case 16 clocks from enqueue to strobe. CPU_BUSY falls in the clock after the last write's k3.
- Prefetch after a write lands in the next CPU window, ≥16 clocks later (or earlier in a stolen window).
- Reset values: SLOT = 0, queue empty, all strobes high, E_OE = F_OE = 0, B = C = 0, all data outputs 0, VRAMADDR = VRAMMOD = 0, CPU_BUSY = CPU_OVF = REN_ACK = REN_VALID = 0.
- RESET mid-window: the access is aborted and strobes go high at that edge. No partial write is retried.

## Configuration
- VRAM_SLOT_STEAL_EN defined: an idle renderer window (no REN_REQ at start) serves the CPU queue or prefetch with the same priority and phasing.
- VRAM_SLOT_STEAL_EN undefined: idle renderer windows stay idle; the CPU only uses window 12.

## Structure
- Shared package lspc_pkg: slot constants (WIN_REN0 = 0, WIN_REN1 = 4, WIN_REN2 = 8, WIN_CPU = 12), phase enum (PH_ADDR, PH_STB1, PH_STB2, PH_DATA), owner enum (OWN_NONE, OWN_REN, OWN_CPU_WR, OWN_CPU_PF).
- One sub-module: lspc_vram_wfifo (CPU write queue, {addr, data}, depth FIFO_DEPTH, full/empty flags).

## Test plan
- Reset, REN_REQ = 1 with REN_ADDR = 0x0123 at SLOT 0 → B = 0x0123, nBOE low for 4 clocks; REN_VALID at SLOT 3 with REN_DATA = E_IN.
- MOD = 1, ADDR = 0x7000, write 0xBEEF → nBWE low at SLOT 13–14 with E_OUT = 0xBEEF; VRAMADDR then 0x7001; the next window-12 read returns the word at 0x7001 in CPU_RDATA.
- ADDR = 0x8805, write 0x1234 → C = 0x005, nCWE pulses; nBWE stays high.
- MOD = 0xFFFF, ADDR = 0x0000, write → VRAMADDR wraps to 0xFFFF.
- Three writes within 1 clock gap each with FIFO_DEPTH = 2 → third dropped; CPU_OVF = 1 until RESET.
- With VRAM_SLOT_STEAL_EN and REN_REQ = 0, a write issued at SLOT 2 strobes at SLOT 5–6. Without the macro it strobes at SLOT 13–14.

Source files
------------

// File: rtl/lspc_pkg.sv
// Shared definitions for the LSPC VRAM slot scheduler: window start slots,
// window phase and access-owner encodings, and the CPU write-queue entry.
package lspc_pkg;

    localparam logic [3:0] WIN_REN0 = 4'd0;
    localparam logic [3:0] WIN_REN1 = 4'd4;
    localparam logic [3:0] WIN_REN2 = 4'd8;
    localparam logic [3:0] WIN_CPU  = 4'd12;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_STB1 = 2'd1,
        PH_STB2 = 2'd2,
        PH_DATA = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_REN    = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_CPU_PF = 2'd3
    } owner_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_entry_t;

endpackage

// File: rtl/lspc_vram_sched_if.sv
// Register-port (VRAMADDR/VRAMRW/VRAMMOD) and renderer fetch-port bundle
// between the LSPC front end (master) and the VRAM scheduler (slave).
interface lspc_vram_sched_if;

    logic        CPU_ADDR_WE;
    logic        CPU_RW_WE;
    logic        CPU_MOD_WE;
    logic [15:0] CPU_DATA;
    logic [15:0] CPU_RDATA;
    logic [15:0] CPU_VRAMADDR;
    logic [15:0] CPU_VRAMMOD;
    logic        CPU_BUSY;
    logic        CPU_OVF;
    logic        REN_REQ;
    logic [15:0] REN_ADDR;
    logic        REN_ACK;
    logic        REN_VALID;
    logic [15:0] REN_DATA;

    modport master (
        output CPU_ADDR_WE, CPU_RW_WE, CPU_MOD_WE, CPU_DATA, REN_REQ, REN_ADDR,
        input  CPU_RDATA, CPU_VRAMADDR, CPU_VRAMMOD, CPU_BUSY, CPU_OVF,
               REN_ACK, REN_VALID, REN_DATA
    );

    modport slave (
        input  CPU_ADDR_WE, CPU_RW_WE, CPU_MOD_WE, CPU_DATA, REN_REQ, REN_ADDR,
        output CPU_RDATA, CPU_VRAMADDR, CPU_VRAMMOD, CPU_BUSY, CPU_OVF,
               REN_ACK, REN_VALID, REN_DATA
    );

endinterface

// File: rtl/lspc_vram_wfifo.sv
// CPU write queue: {addr, data} entries, DEPTH a power of two (>= 2).
// Head entry stays stable until popped, so it can drive a whole window.
module lspc_vram_wfifo
    import lspc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wr_entry_t din,
    input  logic      pop,
    output wr_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_entry_t       mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lspc_vram_sched.sv
// LSPC VRAM time-slot scheduler. 16-clock frame, four 4-clock windows:
// SLOT 0/4/8 renderer, SLOT 12 CPU. Owns all lower/upper VRAM strobes.
// Optional macro VRAM_SLOT_STEAL_EN: an idle renderer window serves the CPU.
module lspc_vram_sched
    import lspc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               CLK_24M,
    input  logic               RESET,
    lspc_vram_sched_if.slave   bus,
    output logic [14:0]        B,
    output logic               nBOE,
    output logic               nBWE,
    output logic [15:0]        E_OUT,
    input  logic [15:0]        E_IN,
    output logic               E_OE,
    output logic [10:0]        C,
    output logic               nCWE,
    output logic [15:0]        F_OUT,
    input  logic [15:0]        F_IN,
    output logic               F_OE
);

    logic [3:0]  slot;
    phase_t      phase;
    owner_t      owner_q, owner_cur;
    logic [15:0] vramaddr, vrammod, pf_addr_q, acc_addr, rd_data;
    logic [15:0] rdata, ren_data;
    logic        pf_pending, pf_kill, ovf, ren_ack, ren_valid;
    logic        ren_win, cpu_win, upper, is_wr, is_rd, stb, wr_done;
    logic        fifo_full, fifo_empty;
    wr_entry_t   fifo_din, head;

    assign phase   = phase_t'(slot[1:0]);
    assign ren_win = (slot == WIN_REN0) || (slot == WIN_REN1) || (slot == WIN_REN2);
`ifdef VRAM_SLOT_STEAL_EN
    assign cpu_win = (slot == WIN_CPU) || ren_win;
`else
    assign cpu_win = (slot == WIN_CPU);
`endif

    // Owner decision at window start; held for the remaining three phases.
    always_comb begin
        owner_cur = owner_q;
        if (phase == PH_ADDR) begin
            owner_cur = OWN_NONE;
            if (ren_win && bus.REN_REQ) owner_cur = OWN_REN;
            else if (cpu_win && !fifo_empty) owner_cur = OWN_CPU_WR;
            else if (cpu_win && pf_pending) owner_cur = OWN_CPU_PF;
        end
        if (RESET) owner_cur = OWN_NONE;
    end

    // Owner state register.
    always_ff @(posedge CLK_24M) begin
        if (RESET) owner_q <= OWN_NONE;
        else       owner_q <= owner_cur;
    end

    // Access address and VRAM pin drive for the current phase.
    always_comb begin
        acc_addr = '0;
        unique case (owner_cur)
            OWN_REN:    acc_addr = bus.REN_ADDR;
            OWN_CPU_WR: acc_addr = head.addr;
            OWN_CPU_PF: acc_addr = (phase == PH_ADDR) ? vramaddr : pf_addr_q;
            default:    acc_addr = '0;
        endcase
        upper   = acc_addr[15];
        is_wr   = (owner_cur == OWN_CPU_WR);
        is_rd   = (owner_cur == OWN_REN) || (owner_cur == OWN_CPU_PF);
        stb     = (phase == PH_STB1) || (phase == PH_STB2);
        B       = (owner_cur != OWN_NONE && !upper) ? acc_addr[14:0] : '0;
        C       = (owner_cur != OWN_NONE &&  upper) ? acc_addr[10:0] : '0;
        nBOE    = !(is_rd && !upper);
        nBWE    = !(is_wr && !upper && stb);
        nCWE    = !(is_wr &&  upper && stb);
        E_OE    = is_wr && !upper;
        F_OE    = is_wr &&  upper;
        E_OUT   = E_OE ? head.data : '0;
        F_OUT   = F_OE ? head.data : '0;
        rd_data = upper ? F_IN : E_IN;
        wr_done = is_wr && (phase == PH_DATA);
    end

    // An entry captures VRAMADDR as of enqueue; a same-clock address load wins.
    always_comb begin
        fifo_din.addr = bus.CPU_ADDR_WE ? bus.CPU_DATA : vramaddr;
        fifo_din.data = bus.CPU_DATA;
    end

    lspc_vram_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk   (CLK_24M),
        .rst   (RESET),
        .push  (bus.CPU_RW_WE),
        .din   (fifo_din),
        .pop   (wr_done),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Slot counter, CPU registers, prefetch tracking and read-data capture.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            slot       <= '0;
            vramaddr   <= '0;
            vrammod    <= '0;
            pf_addr_q  <= '0;
            pf_pending <= 1'b0;
            pf_kill    <= 1'b0;
            ovf        <= 1'b0;
            rdata      <= '0;
            ren_data   <= '0;
            ren_ack    <= 1'b0;
            ren_valid  <= 1'b0;
        end else begin
            slot      <= slot + 4'd1;
            ren_ack   <= (phase == PH_ADDR) && (owner_cur == OWN_REN);
            ren_valid <= (phase == PH_STB2) && (owner_cur == OWN_REN);
            if ((phase == PH_STB2) && (owner_cur == OWN_REN)) ren_data <= rd_data;
            if (phase == PH_ADDR) pf_addr_q <= vramaddr;
            // An address load during an in-flight prefetch (up to the capture
            // edge) marks its result stale; the new address gets its own prefetch.
            if (phase == PH_ADDR)
                pf_kill <= (owner_cur == OWN_CPU_PF) && bus.CPU_ADDR_WE;
            else if ((owner_cur == OWN_CPU_PF) && bus.CPU_ADDR_WE)
                pf_kill <= 1'b1;
            if ((phase == PH_STB2) && (owner_cur == OWN_CPU_PF) && !pf_kill && !bus.CPU_ADDR_WE)
                rdata <= rd_data;
            if (bus.CPU_ADDR_WE)  vramaddr <= bus.CPU_DATA;
            else if (wr_done)     vramaddr <= vramaddr + vrammod;
            if (bus.CPU_ADDR_WE || wr_done) pf_pending <= 1'b1;
            else if ((phase == PH_ADDR) && (owner_cur == OWN_CPU_PF)) pf_pending <= 1'b0;
            if (bus.CPU_MOD_WE) vrammod <= bus.CPU_DATA;
            if (bus.CPU_RW_WE && fifo_full) ovf <= 1'b1;
        end
    end

    assign bus.CPU_RDATA    = rdata;
    assign bus.CPU_VRAMADDR = vramaddr;
    assign bus.CPU_VRAMMOD  = vrammod;
    assign bus.CPU_BUSY     = !fifo_empty;
    assign bus.CPU_OVF      = ovf;
    assign bus.REN_ACK      = ren_ack;
    assign bus.REN_VALID    = ren_valid;
    assign bus.REN_DATA     = ren_data;

endmodule

// File: tb/tb_lspc_vram_sched.sv
// Directed bench for lspc_vram_sched. VRAM read data is a fixed pattern of
// the address pins: E_IN = {0,B} ^ A5A5, F_IN = {0,C} ^ 5A5A.
module tb_lspc_vram_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] B;
    logic        nBOE, nBWE, E_OE, nCWE, F_OE;
    logic [15:0] E_OUT, E_IN, F_OUT, F_IN;
    logic [10:0] C;
    logic [3:0]  tb_slot;
    int          total = 0;
    int          bad = 0;

    lspc_vram_sched_if bus ();

    lspc_vram_sched #(.FIFO_DEPTH(2)) dut (
        .CLK_24M (clk),
        .RESET   (rst),
        .bus     (bus),
        .B       (B),
        .nBOE    (nBOE),
        .nBWE    (nBWE),
        .E_OUT   (E_OUT),
        .E_IN    (E_IN),
        .E_OE    (E_OE),
        .C       (C),
        .nCWE    (nCWE),
        .F_OUT   (F_OUT),
        .F_IN    (F_IN),
        .F_OE    (F_OE)
    );

    always #5 clk = ~clk;

    assign E_IN = {1'b0, B} ^ 16'hA5A5;
    assign F_IN = {5'b0, C} ^ 16'h5A5A;

    always @(posedge clk) begin
        if (rst) tb_slot <= 4'd0;
        else     tb_slot <= tb_slot + 4'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_slot(input logic [3:0] s);
        for (int i = 0; i < 20 && tb_slot != s; i++) tick();
        if (tb_slot != s) begin
            total++; bad++;
            $display("FAIL wait_slot: actual=%0d required=%0d", tb_slot, s);
        end
    endtask

    task automatic cpu_pulse(input logic a, input logic r, input logic m, input logic [15:0] d);
        bus.CPU_ADDR_WE = a;
        bus.CPU_RW_WE   = r;
        bus.CPU_MOD_WE  = m;
        bus.CPU_DATA    = d;
        tick();
        bus.CPU_ADDR_WE = 1'b0;
        bus.CPU_RW_WE   = 1'b0;
        bus.CPU_MOD_WE  = 1'b0;
        bus.CPU_DATA    = 16'h0000;
    endtask

    task automatic test_reset();
        bus.REN_REQ  = 1'b1;
        bus.REN_ADDR = 16'h0123;
        rst = 1'b1;
        tick(); tick();
        total++; if ({nBOE, nBWE, nCWE, E_OE, F_OE} !== 5'b11100) begin bad++;
            $display("FAIL rst_strobes: actual=%b required=11100", {nBOE, nBWE, nCWE, E_OE, F_OE}); end
        total++; if ({B, C, E_OUT, F_OUT} !== '0) begin bad++;
            $display("FAIL rst_pins: actual=%h required=0", {B, C, E_OUT, F_OUT}); end
        total++; if ({bus.CPU_VRAMADDR, bus.CPU_VRAMMOD, bus.CPU_RDATA, bus.REN_DATA} !== '0) begin bad++;
            $display("FAIL rst_regs: actual=%h required=0", {bus.CPU_VRAMADDR, bus.CPU_VRAMMOD, bus.CPU_RDATA, bus.REN_DATA}); end
        total++; if ({bus.CPU_BUSY, bus.CPU_OVF, bus.REN_ACK, bus.REN_VALID} !== 4'b0000) begin bad++;
            $display("FAIL rst_flags: actual=%b required=0000", {bus.CPU_BUSY, bus.CPU_OVF, bus.REN_ACK, bus.REN_VALID}); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_ren_read();
        // slot 0, request already present
        total++; if (B !== 15'h0123 || nBOE !== 1'b0 || bus.REN_ACK !== 1'b0) begin bad++;
            $display("FAIL ren_k0: actual B=%h nBOE=%b ack=%b required B=0123 nBOE=0 ack=0", B, nBOE, bus.REN_ACK); end
        tick();
        total++; if (bus.REN_ACK !== 1'b1 || nBOE !== 1'b0 || bus.REN_VALID !== 1'b0) begin bad++;
            $display("FAIL ren_k1: actual ack=%b nBOE=%b valid=%b required 1 0 0", bus.REN_ACK, nBOE, bus.REN_VALID); end
        tick();
        total++; if (bus.REN_ACK !== 1'b0 || nBOE !== 1'b0) begin bad++;
            $display("FAIL ren_k2: actual ack=%b nBOE=%b required 0 0", bus.REN_ACK, nBOE); end
        tick();
        total++; if (bus.REN_VALID !== 1'b1 || bus.REN_DATA !== 16'hA486 || nBOE !== 1'b0) begin bad++;
            $display("FAIL ren_k3: actual valid=%b data=%h nBOE=%b required 1 a486 0", bus.REN_VALID, bus.REN_DATA, nBOE); end
        bus.REN_ADDR = 16'h8ABC;
        tick();
        total++; if (C !== 11'h2BC || B !== 15'h0 || nBOE !== 1'b1 || bus.REN_VALID !== 1'b0) begin bad++;
            $display("FAIL ren_up_k0: actual C=%h B=%h nBOE=%b valid=%b required 2bc 0 1 0", C, B, nBOE, bus.REN_VALID); end
        tick(); tick(); tick();
        total++; if (bus.REN_VALID !== 1'b1 || bus.REN_DATA !== 16'h58E6) begin bad++;
            $display("FAIL ren_up_k3: actual valid=%b data=%h required 1 58e6", bus.REN_VALID, bus.REN_DATA); end
        bus.REN_ADDR = 16'h0000;
        tick();
    endtask

    task automatic test_cpu_lower();
        wait_slot(4'd0);
        cpu_pulse(1'b0, 1'b0, 1'b1, 16'h0001);
        cpu_pulse(1'b1, 1'b0, 1'b0, 16'h7000);
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'hBEEF);
        total++; if (bus.CPU_BUSY !== 1'b1 || bus.CPU_VRAMADDR !== 16'h7000 || bus.CPU_VRAMMOD !== 16'h0001) begin bad++;
            $display("FAIL wr_queued: actual busy=%b addr=%h mod=%h required 1 7000 0001", bus.CPU_BUSY, bus.CPU_VRAMADDR, bus.CPU_VRAMMOD); end
        wait_slot(4'd12);
        total++; if (B !== 15'h7000 || E_OE !== 1'b1 || E_OUT !== 16'hBEEF || nBWE !== 1'b1 || nBOE !== 1'b1) begin bad++;
            $display("FAIL wr_k0: actual B=%h oe=%b dout=%h nBWE=%b nBOE=%b required 7000 1 beef 1 1", B, E_OE, E_OUT, nBWE, nBOE); end
        tick();
        total++; if (nBWE !== 1'b0 || E_OUT !== 16'hBEEF) begin bad++;
            $display("FAIL wr_k1: actual nBWE=%b dout=%h required 0 beef", nBWE, E_OUT); end
        tick();
        total++; if (nBWE !== 1'b0) begin bad++;
            $display("FAIL wr_k2: actual nBWE=%b required 0", nBWE); end
        tick();
        total++; if (nBWE !== 1'b1 || bus.CPU_BUSY !== 1'b1 || E_OE !== 1'b1) begin bad++;
            $display("FAIL wr_k3: actual nBWE=%b busy=%b oe=%b required 1 1 1", nBWE, bus.CPU_BUSY, E_OE); end
        tick();
        total++; if (bus.CPU_BUSY !== 1'b0 || bus.CPU_VRAMADDR !== 16'h7001) begin bad++;
            $display("FAIL wr_done: actual busy=%b addr=%h required 0 7001", bus.CPU_BUSY, bus.CPU_VRAMADDR); end
        wait_slot(4'd12);
        total++; if (B !== 15'h7001 || nBOE !== 1'b0 || E_OE !== 1'b0) begin bad++;
            $display("FAIL pf_k0: actual B=%h nBOE=%b oe=%b required 7001 0 0", B, nBOE, E_OE); end
        tick(); tick();
        total++; if (bus.CPU_RDATA !== 16'h0000) begin bad++;
            $display("FAIL pf_k2: actual rdata=%h required 0000", bus.CPU_RDATA); end
        tick();
        total++; if (bus.CPU_RDATA !== 16'hD5A4) begin bad++;
            $display("FAIL pf_k3: actual rdata=%h required d5a4", bus.CPU_RDATA); end
    endtask

    task automatic test_cpu_upper();
        wait_slot(4'd0);
        cpu_pulse(1'b1, 1'b0, 1'b0, 16'h8805);
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'h1234);
        wait_slot(4'd12);
        total++; if (C !== 11'h005 || F_OE !== 1'b1 || F_OUT !== 16'h1234 || nCWE !== 1'b1 || B !== 15'h0 || E_OE !== 1'b0) begin bad++;
            $display("FAIL up_k0: actual C=%h foe=%b fout=%h nCWE=%b B=%h eoe=%b required 005 1 1234 1 0 0", C, F_OE, F_OUT, nCWE, B, E_OE); end
        tick();
        total++; if (nCWE !== 1'b0 || nBWE !== 1'b1) begin bad++;
            $display("FAIL up_k1: actual nCWE=%b nBWE=%b required 0 1", nCWE, nBWE); end
        tick();
        total++; if (nCWE !== 1'b0 || nBWE !== 1'b1) begin bad++;
            $display("FAIL up_k2: actual nCWE=%b nBWE=%b required 0 1", nCWE, nBWE); end
        tick();
        total++; if (nCWE !== 1'b1) begin bad++;
            $display("FAIL up_k3: actual nCWE=%b required 1", nCWE); end
        tick();
        total++; if (bus.CPU_VRAMADDR !== 16'h8806) begin bad++;
            $display("FAIL up_inc: actual addr=%h required 8806", bus.CPU_VRAMADDR); end
    endtask

    task automatic test_wrap();
        wait_slot(4'd0);
        cpu_pulse(1'b0, 1'b0, 1'b1, 16'hFFFF);
        cpu_pulse(1'b1, 1'b0, 1'b0, 16'h0000);
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'h5555);
        wait_slot(4'd12);
        total++; if (B !== 15'h0 || E_OE !== 1'b1 || E_OUT !== 16'h5555) begin bad++;
            $display("FAIL wrap_wr: actual B=%h oe=%b dout=%h required 0 1 5555", B, E_OE, E_OUT); end
        wait_slot(4'd0);
        total++; if (bus.CPU_VRAMADDR !== 16'hFFFF) begin bad++;
            $display("FAIL wrap_addr: actual addr=%h required ffff", bus.CPU_VRAMADDR); end
        wait_slot(4'd15);
        total++; if (bus.CPU_RDATA !== 16'h5DA5) begin bad++;
            $display("FAIL wrap_pf: actual rdata=%h required 5da5", bus.CPU_RDATA); end
    endtask

    task automatic test_overflow();
        wait_slot(4'd0);
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'h1111);
        tick();
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'h2222);
        total++; if (bus.CPU_OVF !== 1'b0 || bus.CPU_BUSY !== 1'b1) begin bad++;
            $display("FAIL ovf_two: actual ovf=%b busy=%b required 0 1", bus.CPU_OVF, bus.CPU_BUSY); end
        tick();
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'h3333);
        total++; if (bus.CPU_OVF !== 1'b1) begin bad++;
            $display("FAIL ovf_three: actual ovf=%b required 1", bus.CPU_OVF); end
        wait_slot(4'd12);
        total++; if (F_OE !== 1'b1 || F_OUT !== 16'h1111 || C !== 11'h7FF) begin bad++;
            $display("FAIL ovf_wr1: actual foe=%b fout=%h C=%h required 1 1111 7ff", F_OE, F_OUT, C); end
        wait_slot(4'd0);
        wait_slot(4'd12);
        total++; if (F_OE !== 1'b1 || F_OUT !== 16'h2222) begin bad++;
            $display("FAIL ovf_wr2: actual foe=%b fout=%h required 1 2222", F_OE, F_OUT); end
        wait_slot(4'd0);
        total++; if (bus.CPU_BUSY !== 1'b0 || bus.CPU_VRAMADDR !== 16'hFFFD || bus.CPU_OVF !== 1'b1) begin bad++;
            $display("FAIL ovf_drain: actual busy=%b addr=%h ovf=%b required 0 fffd 1", bus.CPU_BUSY, bus.CPU_VRAMADDR, bus.CPU_OVF); end
        wait_slot(4'd12);
        total++; if (F_OE !== 1'b0 || E_OE !== 1'b0) begin bad++;
            $display("FAIL ovf_nowr3: actual foe=%b eoe=%b required 0 0", F_OE, E_OE); end
        rst = 1'b1;
        tick();
        total++; if (bus.CPU_OVF !== 1'b0) begin bad++;
            $display("FAIL ovf_clear: actual ovf=%b required 0", bus.CPU_OVF); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_steal();
        logic steal;
`ifdef VRAM_SLOT_STEAL_EN
        steal = 1'b1;
`else
        steal = 1'b0;
`endif
        bus.REN_REQ = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        wait_slot(4'd2);
        cpu_pulse(1'b0, 1'b1, 1'b0, 16'hCAFE);
        tick();
        total++; if (E_OE !== steal) begin bad++;
            $display("FAIL steal_k0: actual oe=%b required %b", E_OE, steal); end
        tick();
        total++; if (nBWE !== !steal) begin bad++;
            $display("FAIL steal_s5: actual nBWE=%b required %b", nBWE, !steal); end
        tick();
        total++; if (nBWE !== !steal) begin bad++;
            $display("FAIL steal_s6: actual nBWE=%b required %b", nBWE, !steal); end
        wait_slot(4'd13);
        total++; if (nBWE !== steal) begin bad++;
            $display("FAIL steal_s13: actual nBWE=%b required %b", nBWE, steal); end
        tick();
        total++; if (nBWE !== steal) begin bad++;
            $display("FAIL steal_s14: actual nBWE=%b required %b", nBWE, steal); end
    endtask

    initial begin
        bus.CPU_ADDR_WE = 1'b0;
        bus.CPU_RW_WE   = 1'b0;
        bus.CPU_MOD_WE  = 1'b0;
        bus.CPU_DATA    = 16'h0000;
        bus.REN_REQ     = 1'b0;
        bus.REN_ADDR    = 16'h0000;
        #3;
        test_reset();
        test_ren_read();
        test_cpu_lower();
        test_cpu_upper();
        test_wrap();
        test_overflow();
        test_steal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
